lrn_layer_scheduler: RTL and testbench

- Queues LRN layer descriptors (dim4..dim1, padding) from the host/config bus and sequences the LRN mapper one layer at a time.
- For each layer it drives the mapper config, issues a single-cycle start_normalization and waits for normalized_layer.
- Runs a completion watchdog, counts finished layers and raises a done pulse.
- Sits between the config register block and the LRN mapper/divider datapath.

---
 rtl/lrn_sched_pkg.sv | 36 +++
 rtl/lrn_desc_fifo.sv | 68 ++++++
 rtl/lrn_layer_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_lrn_layer_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lrn_sched_pkg.sv
// Shared types for the LRN layer scheduler: FSM states,
// the queued layer descriptor and the default queue depth.
package lrn_sched_pkg;

    localparam int N_W = 2;
    localparam int M_W = 10;
    localparam int E_W = 6;
    localparam int F_W = 6;
    localparam int V_W = 2;

    localparam int SCHED_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DRAIN,
        S_ERR
    } sched_state_t;

    typedef struct packed {
        logic [N_W-1:0] dim4;
        logic [M_W-1:0] dim3;
        logic [E_W-1:0] dim2;
        logic [F_W-1:0] dim1;
        logic [V_W-1:0] padding;
    } lrn_desc_t;

    // Padding may legally be zero; only the four dimensions are checked.
    function automatic logic desc_has_zero(input lrn_desc_t d);
        return (d.dim4 == '0) || (d.dim3 == '0) ||
               (d.dim2 == '0) || (d.dim1 == '0);
    endfunction

endpackage

// File: rtl/lrn_desc_fifo.sv
// Synchronous descriptor FIFO with flush, full/empty and occupancy.
// Ports: i_clk, i_rst (async high), i_flush, i_push/i_wdata, i_pop,
//        o_rdata (head entry), o_full, o_empty, o_count.
module lrn_desc_fifo
    import lrn_sched_pkg::*;
#(
    parameter int DEPTH = SCHED_FIFO_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  lrn_desc_t                i_wdata,
    input  logic                     i_pop,
    output lrn_desc_t                o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    lrn_desc_t         r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lrn_layer_scheduler.sv
// Queues LRN layer descriptors and sequences the mapper one layer at a time.
// Ports: cfg_* descriptor input, map_*/start_normalization to the mapper,
//        normalized_layer completion, busy/layer_done/count/error status.
module lrn_layer_scheduler
    import lrn_sched_pkg::*;
#(
    parameter int N_WIDTH    = 2,
    parameter int M_WIDTH    = 10,
    parameter int E_WIDTH    = 6,
    parameter int F_WIDTH    = 6,
    parameter int V_WIDTH    = 2,
    parameter int FIFO_DEPTH = SCHED_FIFO_DEPTH,
    parameter int TO_WIDTH   = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 core_clk,
    input  logic                 reset,
    input  logic                 sched_enable,
    input  logic                 abort,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [N_WIDTH-1:0]   cfg_dim4,
    input  logic [M_WIDTH-1:0]   cfg_dim3,
    input  logic [E_WIDTH-1:0]   cfg_dim2,
    input  logic [F_WIDTH-1:0]   cfg_dim1,
    input  logic [V_WIDTH-1:0]   cfg_padding,
    input  logic [TO_WIDTH-1:0]  timeout_limit,
    output logic [N_WIDTH-1:0]   map_dim4,
    output logic [M_WIDTH-1:0]   map_dim3,
    output logic [E_WIDTH-1:0]   map_dim2,
    output logic [F_WIDTH-1:0]   map_dim1,
    output logic [V_WIDTH-1:0]   map_padding_num,
    output logic                 start_normalization,
    input  logic                 normalized_layer,
    output logic                 busy,
    output logic                 layer_done,
    output logic [CNT_WIDTH-1:0] layers_done_cnt,
    output logic                 cfg_err,
    output logic                 timeout_err
);

    sched_state_t               r_state;
    lrn_desc_t                  r_map;
    logic                       r_rst_done;
    logic                       r_start;
    logic                       r_busy;
    logic                       r_layer_done;
    logic [CNT_WIDTH-1:0]       r_cnt;
    logic                       r_cfg_err;
    logic                       r_to_err;
    logic [TO_WIDTH-1:0]        r_wd;

    lrn_desc_t                  w_desc_in;
    lrn_desc_t                  w_head;
    logic                       w_full;
    logic                       w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                       w_zero;
    logic                       w_take;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_busy_idle;
    logic                       w_expire;

    assign w_desc_in = '{dim4: cfg_dim4, dim3: cfg_dim3, dim2: cfg_dim2,
                         dim1: cfg_dim1, padding: cfg_padding};
    assign w_zero    = desc_has_zero(w_desc_in);

    // r_rst_done keeps cfg_ready low while reset is held.
    assign cfg_ready = r_rst_done && !w_full && !abort;
    assign w_take    = cfg_valid && cfg_ready;
    assign w_push    = w_take && !w_zero;
    assign w_pop     = (r_state == S_IDLE) && sched_enable &&
                       !w_empty && !abort;

    // Occupancy seen when the next state is IDLE (no pop happens then).
    assign w_busy_idle = (w_count != '0) || w_push;
    assign w_expire    = (timeout_limit != '0) &&
                         (r_wd == timeout_limit - TO_WIDTH'(1));

    lrn_desc_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (core_clk),
        .i_rst   (reset),
        .i_flush (abort),
        .i_push  (w_push),
        .i_wdata (w_desc_in),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_map        <= '0;
            r_rst_done   <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_layer_done <= 1'b0;
            r_cnt        <= '0;
            r_cfg_err    <= 1'b0;
            r_to_err     <= 1'b0;
            r_wd         <= '0;
        end else begin
            r_rst_done   <= 1'b1;
            r_start      <= 1'b0;
            r_layer_done <= 1'b0;
            if (w_take && w_zero) begin
                r_cfg_err <= 1'b1;
            end
            if (abort) begin
                r_state   <= S_IDLE;
                r_wd      <= '0;
                r_to_err  <= 1'b0;
                r_cfg_err <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_pop) begin
                            r_state <= S_LOAD;
                            r_map   <= w_head;
                            r_busy  <= 1'b1;
                        end else begin
                            r_busy <= w_busy_idle;
                        end
                    end
                    S_LOAD: begin
                        r_state <= S_START;
                        r_start <= 1'b1;
                    end
                    S_START: begin
                        r_state <= S_RUN;
                        r_wd    <= '0;
                    end
                    S_RUN: begin
                        // Completion takes precedence over expiry.
                        if (normalized_layer) begin
                            r_state      <= S_DRAIN;
                            r_layer_done <= 1'b1;
                            r_cnt        <= r_cnt + CNT_WIDTH'(1);
                        end else if (w_expire) begin
                            r_state  <= S_ERR;
                            r_to_err <= 1'b1;
                        end else begin
                            r_wd <= r_wd + TO_WIDTH'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (!normalized_layer) begin
                            r_state <= S_IDLE;
                            r_busy  <= w_busy_idle;
                        end
                    end
                    S_ERR: begin
                        r_state <= S_ERR;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign map_dim4            = r_map.dim4;
    assign map_dim3            = r_map.dim3;
    assign map_dim2            = r_map.dim2;
    assign map_dim1            = r_map.dim1;
    assign map_padding_num     = r_map.padding;
    assign start_normalization = r_start;
    assign busy                = r_busy;
    assign layer_done          = r_layer_done;
    assign layers_done_cnt     = r_cnt;
    assign cfg_err             = r_cfg_err;
    assign timeout_err         = r_to_err;

endmodule

// File: tb/tb_lrn_layer_scheduler.sv
// Scoreboard bench for lrn_layer_scheduler: queued descriptors are
// matched against map_* on every start pulse.
module tb_lrn_layer_scheduler;
    import lrn_sched_pkg::*;

    logic        core_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sched_enable = 1'b0;
    logic        abort = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_dim4 = '0;
    logic [9:0]  cfg_dim3 = '0;
    logic [5:0]  cfg_dim2 = '0;
    logic [5:0]  cfg_dim1 = '0;
    logic [1:0]  cfg_padding = '0;
    logic [23:0] timeout_limit = '0;
    logic [1:0]  map_dim4;
    logic [9:0]  map_dim3;
    logic [5:0]  map_dim2;
    logic [5:0]  map_dim1;
    logic [1:0]  map_padding_num;
    logic        start_normalization;
    logic        normalized_layer = 1'b0;
    logic        busy;
    logic        layer_done;
    logic [15:0] layers_done_cnt;
    logic        cfg_err;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;
    int n_done  = 0;
    int exp_cnt = 0;
    lrn_desc_t sb[$];

    always #5 core_clk = ~core_clk;

    lrn_layer_scheduler dut (
        .core_clk            (core_clk),
        .reset               (reset),
        .sched_enable        (sched_enable),
        .abort               (abort),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_dim4            (cfg_dim4),
        .cfg_dim3            (cfg_dim3),
        .cfg_dim2            (cfg_dim2),
        .cfg_dim1            (cfg_dim1),
        .cfg_padding         (cfg_padding),
        .timeout_limit       (timeout_limit),
        .map_dim4            (map_dim4),
        .map_dim3            (map_dim3),
        .map_dim2            (map_dim2),
        .map_dim1            (map_dim1),
        .map_padding_num     (map_padding_num),
        .start_normalization (start_normalization),
        .normalized_layer    (normalized_layer),
        .busy                (busy),
        .layer_done          (layer_done),
        .layers_done_cnt     (layers_done_cnt),
        .cfg_err             (cfg_err),
        .timeout_err         (timeout_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge core_clk);
            #1;
        end
    endtask

    task automatic push_desc(input int d4, input int d3, input int d2,
                             input int d1, input int pad,
                             output logic acc);
        lrn_desc_t d;
        d.dim4    = 2'(d4);
        d.dim3    = 10'(d3);
        d.dim2    = 6'(d2);
        d.dim1    = 6'(d1);
        d.padding = 2'(pad);
        cfg_dim4    = d.dim4;
        cfg_dim3    = d.dim3;
        cfg_dim2    = d.dim2;
        cfg_dim1    = d.dim1;
        cfg_padding = d.padding;
        cfg_valid   = 1'b1;
        #1;
        acc = cfg_ready;
        tick();
        cfg_valid = 1'b0;
        if (acc && d4 != 0 && d3 != 0 && d2 != 0 && d1 != 0)
            sb.push_back(d);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 30 && !start_normalization; i++)
            tick();
        chk("start_seen", start_normalization, 1);
    endtask

    task automatic run_layer(input int hold);
        int d0;
        wait_start();
        tick(3);
        d0 = n_done;
        normalized_layer = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("no_restart_hold", start_normalization, 0);
        end
        normalized_layer = 1'b0;
        tick(2);
        exp_cnt++;
        chk("done_once", n_done - d0, 1);
        chk("cnt", layers_done_cnt, exp_cnt);
    endtask

    initial begin : mon
        lrn_desc_t e;
        forever begin
            @(negedge core_clk);
            if (start_normalization) begin
                n_starts++;
                if (sb.size() == 0) begin
                    chk("start_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("map_desc", {map_dim4, map_dim3, map_dim2,
                                     map_dim1, map_padding_num}, e);
                end
            end
            if (layer_done)
                n_done++;
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench did not finish");
    end

    initial begin : main
        logic acc;
        int   s0;

        // Reset state
        tick(2);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_normalization, 0);
        chk("rst_cnt", layers_done_cnt, 0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", cfg_ready, 1);

        // Single layer with exact latency
        sched_enable = 1'b1;
        push_desc(2, 4, 3, 3, 1, acc);
        chk("t1_acc", acc, 1);
        chk("t1_start_k", start_normalization, 0);
        tick();
        chk("t1_map", {map_dim4, map_dim3, map_dim2, map_dim1,
                       map_padding_num}, {2'd2, 10'd4, 6'd3, 6'd3, 2'd1});
        chk("t1_start_k1", start_normalization, 0);
        tick();
        chk("t1_start_k2", start_normalization, 1);
        tick();
        chk("t1_start_k3", start_normalization, 0);
        chk("t1_busy_run", busy, 1);
        tick(9);
        normalized_layer = 1'b1;
        tick();
        chk("t1_done", layer_done, 1);
        chk("t1_cnt", layers_done_cnt, 1);
        normalized_layer = 1'b0;
        tick();
        chk("t1_done_low", layer_done, 0);
        chk("t1_idle", busy, 0);
        exp_cnt = 1;

        // Fill queue while disabled
        sched_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_desc(i % 3 + 1, 10 + i, 2 + i, 3, i % 4, acc);
            chk("t2_acc", acc, (i < 4) ? 1 : 0);
        end
        chk("t2_ready_full", cfg_ready, 0);
        chk("t2_busy_q", busy, 1);
        s0 = n_starts;
        sched_enable = 1'b1;
        repeat (4) run_layer(1);
        chk("t2_starts", n_starts - s0, 4);
        chk("t2_idle", busy, 0);

        // Level-held completion, second layer queued behind it
        push_desc(1, 7, 5, 5, 2, acc);
        push_desc(3, 9, 1, 2, 0, acc);
        run_layer(6);
        run_layer(1);

        // Watchdog expiry and abort
        timeout_limit = 24'd20;
        push_desc(1, 1, 1, 1, 0, acc);
        push_desc(2, 2, 2, 2, 0, acc);
        wait_start();
        tick();
        tick(19);
        chk("t4_to_before", timeout_err, 0);
        tick();
        chk("t4_to_set", timeout_err, 1);
        chk("t4_busy_err", busy, 1);
        s0 = n_starts;
        tick(10);
        chk("t4_no_start_err", n_starts - s0, 0);
        abort = 1'b1;
        #1;
        chk("t4_ready_abort", cfg_ready, 0);
        tick();
        abort = 1'b0;
        sb.delete();
        chk("t4_to_clr", timeout_err, 0);
        chk("t4_flushed", busy, 0);
        tick(10);
        chk("t4_no_start_flush", n_starts - s0, 0);
        timeout_limit = '0;

        // Zero-dimension descriptor
        sched_enable = 1'b0;
        push_desc(1, 0, 2, 2, 0, acc);
        chk("t5_acc", acc, 1);
        chk("t5_err", cfg_err, 1);
        chk("t5_empty", busy, 0);
        sched_enable = 1'b1;
        s0 = n_starts;
        tick(8);
        chk("t5_no_start", n_starts - s0, 0);
        push_desc(3, 1, 63, 63, 3, acc);
        run_layer(1);
        chk("t5_err_sticky", cfg_err, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_err_clr", cfg_err, 0);
        chk("t5_cnt_kept", layers_done_cnt, exp_cnt);

        // Reset during RUN
        push_desc(2, 5, 4, 4, 1, acc);
        wait_start();
        tick(2);
        reset = 1'b1;
        #1;
        chk("t6_start", start_normalization, 0);
        chk("t6_map", {map_dim4, map_dim3, map_dim2, map_dim1,
                       map_padding_num}, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cnt", layers_done_cnt, 0);
        chk("t6_ready", cfg_ready, 0);
        chk("t6_errs", {cfg_err, timeout_err, layer_done}, 0);
        sb.delete();
        exp_cnt = 0;
        tick(2);
        reset = 1'b0;
        tick();
        chk("t6_ready_back", cfg_ready, 1);
        s0 = n_starts;
        tick(10);
        chk("t6_no_start", n_starts - s0, 0);
        chk("t6_empty", busy, 0);
        push_desc(1, 3, 3, 3, 2, acc);
        run_layer(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
